// File: rtl/binary2bcd_seq_wfs.sv
// ============================================================================
// binary2bcd_seq_wfs : sequential shift-and-add-3 binary-to-BCD converter.
// Optional build macro BIN2BCD_SAT_EN: saturate bcd_wfs to all 9s on overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module binary2bcd_seq_wfs #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  start,
   input  logic [BIN_W-1:0]      binary_wfs,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_wfs,
   output logic                  ovf
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int ITER_W = $clog2(BIN_W + 1);
   localparam int CMP_W  = BIN_W + BCD_W;
   localparam logic [CMP_W-1:0]  LIMIT = CMP_W'(10 ** DIGITS);
   localparam logic [ITER_W-1:0] LAST  = ITER_W'(BIN_W - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                load;
   logic                last;

   logic [BIN_W-1:0]    bin_sr;
   logic [BCD_W-1:0]    scratch;
   logic [ITER_W-1:0]   iter;
   logic                ovf_p;
   logic                ovf_cmp;
   logic [BCD_W-1:0]    adj;
   logic [BCD_W-1:0]    shifted;
   logic [BCD_W-1:0]    result;

   // Digit correction: no carry between digits, each nibble is independent.
   for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      assign adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ?
                             (scratch[4*d +: 4] + 4'd3) : scratch[4*d +: 4];
   end

   // Top bit of the top digit falls off, which yields value mod 10**DIGITS.
   assign shifted = {adj[BCD_W-2:0], bin_sr[BIN_W-1]};
   assign ovf_cmp = ({{BCD_W{1'b0}}, binary_wfs} >= LIMIT);

`ifdef BIN2BCD_SAT_EN
   assign result = ovf_p ? {DIGITS{4'h9}} : shifted;
`else
   assign result = shifted;
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (iter == LAST) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         bin_sr  <= '0;
         scratch <= '0;
         iter    <= '0;
         ovf_p   <= 1'b0;
         done    <= 1'b0;
         bcd_wfs <= '0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            scratch <= '0;
            bin_sr  <= binary_wfs;
            iter    <= '0;
            ovf_p   <= ovf_cmp;
         end else if (state == SHIFT) begin
            scratch <= shifted;
            bin_sr  <= bin_sr << 1;
            iter    <= iter + ITER_W'(1);
            if (last) begin
               done    <= 1'b1;
               bcd_wfs <= result;
               ovf     <= ovf_p;
            end
         end
      end
   end

endmodule

`default_nettype wire
